// File: rtl/led_pattern_decoder_pkg.sv
// ============================================================================
// Module      : led_dec_pkg
// Description : Shared types and constants for the LED pattern decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam int SW_EN      = 0;
    localparam int SW_SPD_LSB = 1;
    localparam int SW_COLOR   = 3;

    localparam logic [1:0] SPD_R0 = 2'd0;
    localparam logic [1:0] SPD_R1 = 2'd1;
    localparam logic [1:0] SPD_R2 = 2'd2;
    localparam logic [1:0] SPD_R3 = 2'd3;

    // True when period p lies within lim +/- tol (inclusive).
    function automatic logic in_window(input int p, input int lim, input int tol);
        return (p >= lim - tol) && (p <= lim + tol);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_decoder_if.sv
// ============================================================================
// Module      : led_pattern_decoder_if
// Description : LED observation inputs and decoded-switch outputs bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pattern_decoder_if #(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 16,
    parameter int NB_SW      = 4
) ();

    logic [NB_LEDS-1:0]    i_led;
    logic [NB_LEDS-1:0]    i_led_b;
    logic [NB_LEDS-1:0]    i_led_g;
    logic [NB_SW-1:0]      o_sw;
    logic                  o_valid;
    logic                  o_error;
    logic [NB_COUNTER-1:0] o_period;
    logic [NB_LEDS-1:0]    o_led_mon;

    modport master (
        output i_led, i_led_b, i_led_g,
        input  o_sw, o_valid, o_error, o_period, o_led_mon
    );

    modport slave (
        input  i_led, i_led_b, i_led_g,
        output o_sw, o_valid, o_error, o_period, o_led_mon
    );

endinterface

`default_nettype wire

// File: rtl/led_pattern_decoder_period_meter.sv
// ============================================================================
// Module      : led_period_meter
// Description : Pattern change detector with saturating shift-period counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_period_meter #(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 16,
    parameter int STALL_CYC  = 512
) (
    input  wire logic                  clock,
    input  wire logic                  i_reset,
    input  wire logic [NB_LEDS-1:0]    i_pattern,
    input  wire logic                  i_clear,
    output logic                       o_change,
    output logic                       o_stall,
    output logic [NB_LEDS-1:0]         o_prev,
    output logic [NB_COUNTER-1:0]      o_meas,
    output logic [NB_COUNTER-1:0]      o_period
);

    localparam logic [NB_COUNTER-1:0] C_CNT_MAX    = '1;
    localparam logic [NB_COUNTER-1:0] C_STALL_LAST = NB_COUNTER'(STALL_CYC - 1);

    logic [NB_LEDS-1:0]    r_prev;
    logic [NB_COUNTER-1:0] r_count;
    logic [NB_COUNTER-1:0] r_period;

    // Stall fires on the cycle the count steps onto STALL_CYC; a change wins.
    always_comb begin
        o_change = (i_pattern != r_prev);
        o_meas   = (r_count == C_CNT_MAX) ? C_CNT_MAX : r_count + NB_COUNTER'(1);
        o_stall  = !o_change && (r_count == C_STALL_LAST);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_prev   <= '0;
            r_count  <= '0;
            r_period <= '0;
        end else begin
            r_prev <= i_pattern;
            if (o_change) begin
                r_period <= o_meas;
                r_count  <= '0;
            end else if (i_clear) begin
                r_count <= '0;
            end else if (r_count != C_CNT_MAX) begin
                r_count <= r_count + NB_COUNTER'(1);
            end
        end
    end

    assign o_prev   = r_prev;
    assign o_period = r_period;

endmodule

`default_nettype wire

// File: rtl/led_pattern_decoder.sv
// ============================================================================
// Module      : led_pattern_decoder
// Description : Rebuilds {color, speed, enable} from observed LED shift patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_decoder
    import led_dec_pkg::*;
#(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 16,
    parameter int NB_SW      = 4,
    parameter int LIM_R0     = 16,
    parameter int LIM_R1     = 32,
    parameter int LIM_R2     = 64,
    parameter int LIM_R3     = 128,
    parameter int TOL        = 2,
    parameter int STALL_CYC  = 512
) (
    input  wire logic              clock,
    input  wire logic              i_reset,
    led_pattern_decoder_if.slave   bus
);

    localparam int C_LIM [0:3] = '{LIM_R0, LIM_R1, LIM_R2, LIM_R3};

    logic [NB_LEDS-1:0]    r_led;
    logic [NB_LEDS-1:0]    r_led_b;
    logic [NB_LEDS-1:0]    r_led_g;
    state_t                r_state;
    logic [1:0]            r_cand;
    logic [1:0]            r_speed;
    logic                  r_en;
    logic                  r_color;
    logic                  r_valid;
    logic                  r_error;

    logic [NB_LEDS-1:0]    w_pat;
    logic [NB_LEDS-1:0]    w_prev;
    logic [NB_LEDS-1:0]    w_rotl;
    logic                  w_col;
    logic                  w_sel;
    logic                  w_both;
    logic                  w_err_now;
    logic                  w_colchg;
    logic                  w_change;
    logic                  w_stall;
    logic [NB_COUNTER-1:0] w_meas;
    logic [NB_COUNTER-1:0] w_period;
    logic [3:0]            w_win;
    logic                  w_hit;
    logic [1:0]            w_code;
    state_t                w_state_nxt;
    logic [1:0]            w_cand_nxt;
    logic [1:0]            w_spd_nxt;
    logic [NB_SW-1:0]      w_sw;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_led   <= '0;
            r_led_b <= '0;
            r_led_g <= '0;
        end else begin
            r_led   <= bus.i_led;
            r_led_b <= bus.i_led_b;
            r_led_g <= bus.i_led_g;
        end
    end

    // Colour select: exactly one active vector drives the pattern.
    always_comb begin
        w_pat  = '0;
        w_col  = r_color;
        w_sel  = 1'b0;
        w_both = (|r_led_b) && (|r_led_g);
        if ((|r_led_b) && !(|r_led_g)) begin
            w_pat = r_led_b;
            w_col = 1'b0;
            w_sel = 1'b1;
        end else if ((|r_led_g) && !(|r_led_b)) begin
            w_pat = r_led_g;
            w_col = 1'b1;
            w_sel = 1'b1;
        end
    end

    led_period_meter #(
        .NB_LEDS    (NB_LEDS),
        .NB_COUNTER (NB_COUNTER),
        .STALL_CYC  (STALL_CYC)
    ) u_meter (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_pattern  (w_pat),
        .i_clear    (w_colchg),
        .o_change   (w_change),
        .o_stall    (w_stall),
        .o_prev     (w_prev),
        .o_meas     (w_meas),
        .o_period   (w_period)
    );

    assign w_rotl    = {w_prev[NB_LEDS-2:0], w_prev[NB_LEDS-1]};
    assign w_colchg  = w_sel && (w_col != r_color);
    assign w_err_now = w_both
                     || ((w_pat != '0) && !$onehot(w_pat))
                     || (w_change && (w_prev != '0) && (w_pat != '0) && (w_pat != w_rotl));

    for (genvar k = 0; k < 4; k++) begin : g_win
        assign w_win[k] = in_window(int'(w_meas), C_LIM[k], TOL);
    end

    always_comb begin
        w_hit  = 1'b0;
        w_code = SPD_R0;
        for (int k = 0; k < 4; k++) begin
            if (w_win[k]) begin
                w_hit  = 1'b1;
                w_code = 2'(k);
            end
        end
    end

    // Priority: colour change, then pattern change, then stall.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_spd_nxt   = r_speed;
        if (w_colchg && (r_state != ST_IDLE || !w_err_now)) begin
            w_state_nxt = ST_ARMED;
        end else if (w_change) begin
            if (w_prev == '0 || w_pat == '0) begin
                if (r_state != ST_IDLE || (w_pat != '0 && !w_err_now))
                    w_state_nxt = ST_ARMED;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_err_now) w_state_nxt = ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (w_hit) begin
                            w_state_nxt = ST_CONFIRM;
                            w_cand_nxt  = w_code;
                        end
                    end
                    ST_CONFIRM: begin
                        if (!w_hit) begin
                            w_state_nxt = ST_ARMED;
                        end else if (w_code == r_cand) begin
                            w_state_nxt = ST_LOCKED;
                            w_spd_nxt   = w_code;
                        end else begin
                            w_cand_nxt = w_code;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_hit) begin
                            w_state_nxt = ST_ARMED;
                        end else if (w_code != r_speed) begin
                            w_state_nxt = ST_CONFIRM;
                            w_cand_nxt  = w_code;
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end else if (w_stall) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cand  <= SPD_R0;
            r_speed <= SPD_R0;
            r_en    <= 1'b0;
            r_color <= 1'b0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_speed <= w_spd_nxt;
            r_en    <= (w_state_nxt != ST_IDLE);
            r_color <= w_col;
            r_valid <= (w_state_nxt == ST_LOCKED);
            r_error <= r_error | w_err_now;
        end
    end

    always_comb begin
        w_sw                       = '0;
        w_sw[SW_EN]                = r_en;
        w_sw[SW_SPD_LSB +: 2]      = r_speed;
        w_sw[SW_COLOR]             = r_color;
    end

    assign bus.o_sw      = w_sw;
    assign bus.o_valid   = r_valid;
    assign bus.o_error   = r_error;
    assign bus.o_period  = w_period;
    assign bus.o_led_mon = r_led;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_decoder.sv
// ============================================================================
// Module      : tb_led_pattern_decoder
// Description : Directed self-checking bench for led_pattern_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_decoder;

    logic clock = 1'b0;
    logic i_reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] pat;
    logic       col;

    led_pattern_decoder_if #(.NB_LEDS(4), .NB_COUNTER(16), .NB_SW(4)) bus ();

    led_pattern_decoder #(
        .NB_LEDS(4), .NB_COUNTER(16), .NB_SW(4),
        .LIM_R0(16), .LIM_R1(32), .LIM_R2(64), .LIM_R3(128),
        .TOL(2), .STALL_CYC(512)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive();
        if (col) begin
            bus.i_led_g = pat;
            bus.i_led_b = 4'b0000;
        end else begin
            bus.i_led_b = pat;
            bus.i_led_g = 4'b0000;
        end
        bus.i_led = pat;
    endtask

    task automatic next_shift();
        pat = {pat[2:0], pat[3]};
        drive();
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        tick(n);
        i_reset = 1'b0;
    endtask

    initial begin
        bus.i_led   = 4'b0000;
        bus.i_led_b = 4'b0000;
        bus.i_led_g = 4'b0000;
        i_reset     = 1'b1;

        // Test 1: reset state, blue period 16 locks speed 0
        do_reset(5);
        check_val("rst_sw",      32'(bus.o_sw),      32'h0);
        check_val("rst_valid",   32'(bus.o_valid),   32'h0);
        check_val("rst_error",   32'(bus.o_error),   32'h0);
        check_val("rst_period",  32'(bus.o_period),  32'h0);
        check_val("rst_led_mon", 32'(bus.o_led_mon), 32'h0);
        col = 1'b0; pat = 4'b0001; drive();
        tick(16); next_shift();
        tick(16); next_shift();
        tick(1);
        check_val("t1_valid_early", 32'(bus.o_valid), 32'h0);
        tick(1);
        check_val("t1_valid",   32'(bus.o_valid),   32'h1);
        check_val("t1_sw",      32'(bus.o_sw),      32'h1);
        check_val("t1_period",  32'(bus.o_period),  32'd16);
        check_val("t1_error",   32'(bus.o_error),   32'h0);
        check_val("t1_led_mon", 32'(bus.o_led_mon), 32'b0100);

        // Test 2: green period 64 then 128
        do_reset(2);
        col = 1'b1; pat = 4'b0001; drive();
        tick(64); next_shift();
        tick(64); next_shift();
        tick(2);
        check_val("t2_sw_64",     32'(bus.o_sw),     32'b1101);
        check_val("t2_valid_64",  32'(bus.o_valid),  32'h1);
        check_val("t2_period_64", 32'(bus.o_period), 32'd64);
        tick(126); next_shift();
        tick(2);
        check_val("t2_valid_drop",  32'(bus.o_valid),  32'h0);
        check_val("t2_sw_hold",     32'(bus.o_sw),     32'b1101);
        check_val("t2_period_128",  32'(bus.o_period), 32'd128);
        tick(126); next_shift();
        tick(2);
        check_val("t2_sw_128",    32'(bus.o_sw),    32'b1111);
        check_val("t2_valid_128", 32'(bus.o_valid), 32'h1);

        // Test 3: stall after STALL_CYC cycles without a shift
        tick(126 + 385);
        check_val("t3_en_before", 32'(bus.o_sw),    32'b1111);
        tick(1);
        check_val("t3_sw_stall",  32'(bus.o_sw),    32'b1110);
        check_val("t3_valid",     32'(bus.o_valid), 32'h0);

        // Test 4: both colours active, then a non-rotate shift
        do_reset(2);
        bus.i_led_b = 4'b0001; bus.i_led_g = 4'b0010; bus.i_led = 4'b0001;
        tick(1);
        check_val("t4_both_early", 32'(bus.o_error), 32'h0);
        tick(1);
        check_val("t4_both_err",   32'(bus.o_error), 32'h1);
        bus.i_led_b = 4'b0000; bus.i_led_g = 4'b0000;
        tick(5);
        check_val("t4_sticky",     32'(bus.o_error), 32'h1);
        do_reset(1);
        check_val("t4_err_rst",    32'(bus.o_error), 32'h0);
        col = 1'b0; pat = 4'b0001; drive();
        tick(16);
        pat = 4'b0100; drive();
        tick(1);
        check_val("t4_shift_early", 32'(bus.o_error), 32'h0);
        tick(1);
        check_val("t4_shift_err",   32'(bus.o_error), 32'h1);
        tick(10);
        check_val("t4_shift_sticky", 32'(bus.o_error), 32'h1);

        // Test 5: period 33 locks speed 1, period 40 is unclassified
        do_reset(2);
        col = 1'b0; pat = 4'b0001; drive();
        tick(33); next_shift();
        tick(33); next_shift();
        tick(2);
        check_val("t5_valid_33",  32'(bus.o_valid),  32'h1);
        check_val("t5_sw_33",     32'(bus.o_sw),     32'b0011);
        check_val("t5_period_33", 32'(bus.o_period), 32'd33);
        tick(38); next_shift();
        tick(2);
        check_val("t5_valid_40",  32'(bus.o_valid),  32'h0);
        check_val("t5_period_40", 32'(bus.o_period), 32'd40);
        tick(38); next_shift();
        tick(2);
        check_val("t5_armed_valid", 32'(bus.o_valid), 32'h0);
        check_val("t5_armed_sw",    32'(bus.o_sw),    32'b0011);
        tick(31); next_shift();
        tick(2);
        check_val("t5_confirm_valid", 32'(bus.o_valid), 32'h0);
        tick(31); next_shift();
        tick(2);
        check_val("t5_relock_valid", 32'(bus.o_valid), 32'h1);
        check_val("t5_error",        32'(bus.o_error), 32'h0);

        // Test 6: reset while locked, then relock
        i_reset = 1'b1;
        tick(1);
        check_val("t6_sw",      32'(bus.o_sw),      32'h0);
        check_val("t6_valid",   32'(bus.o_valid),   32'h0);
        check_val("t6_error",   32'(bus.o_error),   32'h0);
        check_val("t6_period",  32'(bus.o_period),  32'h0);
        check_val("t6_led_mon", 32'(bus.o_led_mon), 32'h0);
        i_reset = 1'b0;
        tick(33); next_shift();
        tick(33); next_shift();
        tick(1);
        check_val("t6_relock_early", 32'(bus.o_valid), 32'h0);
        tick(1);
        check_val("t6_relock_valid", 32'(bus.o_valid),  32'h1);
        check_val("t6_relock_sw",    32'(bus.o_sw),     32'b0011);
        check_val("t6_relock_per",   32'(bus.o_period), 32'd33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
